// File: rtl/ppc_gpr_regs.sv
// 32 x 64-bit PowerPC general-purpose register file: two registered read ports,
// two write ports (port 1 has priority), no internal bypass.
module ppc_gpr_regs #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readEn0,
  input  logic [0:ADDR_WIDTH-1] readAddr0,
  output logic [0:DATA_WIDTH-1] readData0,
  input  logic                  readEn1,
  input  logic [0:ADDR_WIDTH-1] readAddr1,
  output logic [0:DATA_WIDTH-1] readData1,
  input  logic                  writeEn0,
  input  logic [0:ADDR_WIDTH-1] writeAddr0,
  input  logic [0:DATA_WIDTH-1] writeData0,
  input  logic                  writeEn1,
  input  logic [0:ADDR_WIDTH-1] writeAddr1,
  input  logic [0:DATA_WIDTH-1] writeData1
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [0:DATA_WIDTH-1] regFile [NUM_REGS];

  // Every entry needs an async clear, so storage is flops rather than block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gEntry
      localparam logic [0:ADDR_WIDTH-1] IDX = ADDR_WIDTH'(gi);
      logic [0:DATA_WIDTH-1] entryReg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entryReg <= '0;
        end else if (writeEn1 && (writeAddr1 == IDX)) begin
          entryReg <= writeData1;
        end else if (writeEn0 && (writeAddr0 == IDX)) begin
          entryReg <= writeData0;
        end
      end

      assign regFile[gi] = entryReg;
    end
  endgenerate

  // Reads sample the pre-edge contents, giving read-old-data on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData0 <= '0;
      readData1 <= '0;
    end else begin
      if (readEn0) readData0 <= regFile[readAddr0];
      if (readEn1) readData1 <= regFile[readAddr1];
    end
  end

endmodule

// File: tb/tb_ppc_gpr_regs.sv
// Directed scoreboard bench for ppc_gpr_regs.
module tb_ppc_gpr_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        readEn0, readEn1, writeEn0, writeEn1;
  logic [0:4]  readAddr0, readAddr1, writeAddr0, writeAddr1;
  logic [0:63] readData0, readData1, writeData0, writeData1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [0:63] exp0;
    logic [0:63] exp1;
  } exp_t;

  exp_t        sbQueue[$];
  logic [0:63] last0 = '0;
  logic [0:63] last1 = '0;
  logic [0:63] model [32];

  ppc_gpr_regs dut (
    .clk(clk), .reset(reset),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(readData0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(readData1),
    .writeEn0(writeEn0), .writeAddr0(writeAddr0), .writeData0(writeData0),
    .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; disabled read ports expect their previous value.
  task automatic cyc(input string tag,
                     input bit re0, input logic [0:4] ra0, input logic [0:63] e0,
                     input bit re1, input logic [0:4] ra1, input logic [0:63] e1,
                     input bit we0, input logic [0:4] wa0, input logic [0:63] wd0,
                     input bit we1, input logic [0:4] wa1, input logic [0:63] wd1);
    exp_t item;
    readEn0 = re0; readAddr0 = ra0; readEn1 = re1; readAddr1 = ra1;
    writeEn0 = we0; writeAddr0 = wa0; writeData0 = wd0;
    writeEn1 = we1; writeAddr1 = wa1; writeData1 = wd1;
    item.tag  = tag;
    item.exp0 = re0 ? e0 : last0;
    item.exp1 = re1 ? e1 : last1;
    last0 = item.exp0;
    last1 = item.exp1;
    sbQueue.push_back(item);
    @(posedge clk);
    #1;
    item = sbQueue.pop_front();
    check({item.tag, "_rd0"}, readData0, item.exp0);
    check({item.tag, "_rd1"}, readData1, item.exp1);
    $display("txn %-10s rd0=%h rd1=%h", item.tag, readData0, readData1);
    readEn0 = 0; readEn1 = 0; writeEn0 = 0; writeEn1 = 0;
  endtask

  initial begin
    reset = 1'b1;
    readEn0 = 0; readEn1 = 0; writeEn0 = 0; writeEn1 = 0;
    readAddr0 = 0; readAddr1 = 0; writeAddr0 = 0; writeAddr1 = 0;
    writeData0 = '0; writeData1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0", readData0, 64'h0);
    check("rst_rd1", readData1, 64'h0);
    reset = 1'b0;

    // Reset contents
    cyc("rst_r0",  1, 0,  0, 1, 31, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst_r31", 1, 31, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

    // Basic write then read
    cyc("wr_r5", 0, 0, 0, 0, 0, 0, 1, 5, 64'h0123456789ABCDEF, 0, 0, 0);
    cyc("rd_r5", 1, 0, 0, 1, 5, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 0);

    // Read-old-data on collision
    cyc("wr_r7", 0, 0, 0, 0, 0, 0, 1, 7, 64'h11, 0, 0, 0);
    cyc("coll_r7", 1, 7, 64'h11, 0, 0, 0, 1, 7, 64'h22, 0, 0, 0);
    cyc("rd_r7", 1, 7, 64'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Dual write, different and same address
    cyc("dw_r3r4", 0, 0, 0, 0, 0, 0, 1, 3, 64'hAAAA, 1, 4, 64'hBBBB);
    cyc("rd_r3r4", 1, 3, 64'hAAAA, 1, 4, 64'hBBBB, 0, 0, 0, 0, 0, 0);
    cyc("dw_r9", 0, 0, 0, 0, 0, 0, 1, 9, 64'h1, 1, 9, 64'h2);
    cyc("rd_r9", 1, 9, 64'h2, 1, 9, 64'h2, 0, 0, 0, 0, 0, 0);

    // Read enable hold
    cyc("rd5_again", 1, 5, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("hold_rd0",  0, 6, 0, 1, 6, 64'h0, 0, 0, 0, 0, 0, 0);

    // Sweep: fill every entry through both ports, then read back
    for (int i = 0; i < 16; i++) begin
      logic [0:63] dEven, dOdd;
      dEven = {32'(2*i) * 32'h01010101, ~(32'(2*i) * 32'h00010001)};
      dOdd  = {32'(2*i+1) * 32'h01010101, ~(32'(2*i+1) * 32'h00010001)};
      model[2*i]   = dEven;
      model[2*i+1] = dOdd;
      cyc("sweep_wr", 0, 0, 0, 0, 0, 0, 1, 5'(2*i), dEven, 1, 5'(2*i+1), dOdd);
    end
    for (int i = 0; i < 32; i++) begin
      cyc("sweep_rd", 1, 5'(i), model[i], 1, 5'(31-i), model[31-i], 0, 0, 0, 0, 0, 0);
    end

    // Async reset pulse between edges
    cyc("wr_r3", 0, 0, 0, 0, 0, 0, 1, 3, 64'h48, 0, 0, 0);
    cyc("rd_r3", 1, 3, 64'h48, 1, 3, 64'h48, 0, 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1;
    check("arst_rd0", readData0, 64'h0);
    check("arst_rd1", readData1, 64'h0);
    $display("txn arst_pulse rd0=%h rd1=%h", readData0, readData1);
    #2 reset = 1'b0;
    last0 = '0; last1 = '0;
    cyc("post_r3", 1, 3, 0, 1, 31, 0, 0, 0, 0, 0, 0, 0);

    // A write coinciding with reset at an edge is discarded
    cyc("wr_r10", 0, 0, 0, 0, 0, 0, 1, 10, 64'h5A5A, 0, 0, 0);
    writeEn0 = 1; writeAddr0 = 10; writeData0 = 64'hFFFF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    writeEn0 = 0;
    reset = 1'b0;
    $display("txn rst_wr_r10 rd0=%h rd1=%h", readData0, readData1);
    cyc("post_r10", 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    if (sbQueue.size() != 0) begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
